// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Purpose  : Shared sizes, state encoding and mux select codes for the
//            mux4 round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_A = 2'b00;
    localparam logic [SEL_W-1:0] SEL_B = 2'b01;
    localparam logic [SEL_W-1:0] SEL_C = 2'b10;
    localparam logic [SEL_W-1:0] SEL_D = 2'b11;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating priority encoder; the scan starts one
//            past ptr and wraps, first set request wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // i == NUM_REQ wraps back onto ptr itself, so the last owner is lowest priority
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin arbiter with bounded bursts driving mux4to1 selects.
//            Optional macro MUX4_RR_ARBITER_PRIO0_EN gives requester 0 fixed
//            priority at every arbitration point.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               sel0,
    output logic               sel1,
    output logic               busy,
    output logic [CNT_W-1:0]   beat_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [CNT_W-1:0]   r_beat;
    logic [CNT_W-1:0]   w_beat_nxt;

    logic               w_found;
    logic [SEL_W-1:0]   w_pick_idx;
    logic [SEL_W-1:0]   w_win_idx;
    logic               w_release;
    logic               w_take;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

`ifdef MUX4_RR_ARBITER_PRIO0_EN
    assign w_win_idx = req[0] ? SEL_A : w_pick_idx;
`else
    assign w_win_idx = w_pick_idx;
`endif

    // While granted, r_sel is the owner index
    assign w_release = (r_state == GRANT) &&
                       (!req[r_sel] || (r_beat == CNT_W'(BURST_MAX)));
    assign w_take    = w_found && ((r_state == IDLE) || w_release);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_beat_nxt  = r_beat;
        if (w_take) begin
            w_state_nxt = GRANT;
            w_ptr_nxt   = w_win_idx;
            w_sel_nxt   = w_win_idx;
            w_grant_nxt = sel_onehot(w_win_idx);
            w_beat_nxt  = CNT_W'(1);
        end else if (r_state == GRANT) begin
            if (w_release) begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_beat_nxt  = '0;
            end else begin
                w_beat_nxt  = r_beat + CNT_W'(1);
            end
        end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_beat_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= SEL_D;
            r_sel   <= SEL_A;
            r_grant <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign grant    = r_grant;
    assign sel0     = r_sel[1];
    assign sel1     = r_sel[0];
    assign busy     = (r_state == GRANT);
    assign beat_cnt = r_beat;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Directed self-checking bench for mux4_rr_arbiter (BURST_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       sel0;
    logic       sel1;
    logic       busy;
    logic [3:0] beat_cnt;

    int n_assert;
    int n_fail;

    mux4_rr_arbiter #(
        .BURST_MAX (4),
        .CNT_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .sel0     (sel0),
        .sel1     (sel1),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic b, input logic [3:0] bc);
        chk({tag, ".grant"}, {4'h0, grant}, {4'h0, g});
        chk({tag, ".sel"}, {6'h0, sel0, sel1}, {6'h0, s});
        chk({tag, ".busy"}, {7'h0, busy}, {7'h0, b});
        chk({tag, ".beat"}, {4'h0, beat_cnt}, {4'h0, bc});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        req = 4'b1111;

        // Reset held two cycles with every request asserted
        repeat (2) @(negedge clk);
        check_out("reset", 4'b0000, 2'b00, 1'b0, 4'd0);

        // Fairness: pointer starts at 3, so requester 0 first, four beats each
        rst = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            check_out($sformatf("fair%0d", i), 4'b0001 << ((i / 4) % 4),
                      2'((i / 4) % 4), 1'b1, 4'((i % 4) + 1));
        end

        // Sole requester 2 re-granted at every burst boundary with no gap
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_out($sformatf("single%0d", i), 4'b0100, 2'b10, 1'b1, 4'((i % 4) + 1));
        end

        // Early release: owner 1 drops at beat 2 while requester 3 waits
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        check_out("early_b1", 4'b0010, 2'b01, 1'b1, 4'd1);
        @(negedge clk);
        check_out("early_b2", 4'b0010, 2'b01, 1'b1, 4'd2);
        req = 4'b1000;
        @(negedge clk);
        check_out("early_hand", 4'b1000, 2'b11, 1'b1, 4'd1);
        req = 4'b0000;
        @(negedge clk);
        check_out("early_idle", 4'b0000, 2'b11, 1'b0, 4'd0);
        @(negedge clk);
        check_out("idle_hold", 4'b0000, 2'b11, 1'b0, 4'd0);

        // Mid-burst reset at beat 3 of owner 1
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check_out("mid_b3", 4'b0010, 2'b01, 1'b1, 4'd3);
        rst = 1'b1;
        @(negedge clk);
        check_out("mid_rst", 4'b0000, 2'b00, 1'b0, 4'd0);
        // Requester 3 also asks: a restarted pointer (3) must still pick 1 first
        rst = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        check_out("mid_regrant", 4'b0010, 2'b01, 1'b1, 4'd1);

        // Owner 2 mid-burst: no preemption, then release with req=1011
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0100;
        @(negedge clk);
        check_out("prio_b1", 4'b0100, 2'b10, 1'b1, 4'd1);
        req = 4'b1111;
        @(negedge clk);
        check_out("nopreempt", 4'b0100, 2'b10, 1'b1, 4'd2);
        req = 4'b1011;
        @(negedge clk);
`ifdef MUX4_RR_ARBITER_PRIO0_EN
        check_out("prio_rel", 4'b0001, 2'b00, 1'b1, 4'd1);
`else
        check_out("prio_rel", 4'b1000, 2'b11, 1'b1, 4'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
